ppu_line_streamer: RTL and testbench



---
 rtl/ppu_line_streamer.sv | 249 ++++++++++++++++++++++++
 tb/tb_ppu_line_streamer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ppu_line_streamer.sv
// rtl/ppu_line_streamer.sv - PPU scanline capture into ping-pong buffers, streamed out as valid/ready pixels
//
// Ports:
//   clk_ppu        PPU clock; the only clock domain
//   resetn         synchronous reset, active-low
//   video          6-bit palette index for the current PPU pixel
//   scanline       PPU scanline 0-261 (visible 0-239)
//   cycle          PPU cycle 0-340 (pixel x = cycle-1 for cycles 1-256)
//   out_valid      pixel available
//   out_ready      consumer accepts pixel
//   out_data       RGB565 pixel, or zero-extended index when the palette is compiled out
//   out_x, out_y   pixel column / row
//   out_sol        high with x=0 of each line
//   out_sof        high with x=0, y=0
//   overflow       sticky, a captured line was dropped
//   lines_dropped  saturating count of dropped lines
//
// Build option: PPU_STREAM_PALETTE_EN enables the 64-entry NES palette ROM.

module ppu_line_streamer (
   input  logic        clk_ppu,
   input  logic        resetn,
   input  logic [5:0]  video,
   input  logic [8:0]  scanline,
   input  logic [8:0]  cycle,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [7:0]  out_x,
   output logic [7:0]  out_y,
   output logic        out_sol,
   output logic        out_sof,
   output logic        overflow,
   output logic [7:0]  lines_dropped
);

   typedef enum logic [1:0] {W_WAIT, W_CAPTURE, W_COMMIT} wr_state_t;
   typedef enum logic       {R_IDLE, R_STREAM} rd_state_t;

   wr_state_t   wr_state, wr_state_n;
   rd_state_t   rd_state, rd_state_n;

   logic        wr_bank;
   logic        rd_bank;
   logic [1:0]  full;
   logic [1:0]  full_n;
   logic [7:0]  row_tag [0:1];

   // Both banks share one array; the bank select is the address MSB.
   logic [5:0]  line_ram [0:511];

   logic [8:0]  rd_cnt;       // pixels issued from the current read bank, 0-256
   logic        s1_valid;
   logic [5:0]  s1_idx;
   logic [7:0]  s1_x;
   logic [7:0]  s1_y;
   logic [15:0] s1_pix;

   logic        ram_we;
   logic [7:0]  wr_addr;
   logic        advance;
   logic        line_done;
   logic        commit;
   logic        wr_free;
   logic        commit_ok;
   logic        drop;
   logic        rd_issue;

   always_comb begin
      ram_we    = (wr_state == W_CAPTURE) && (cycle >= 9'd1) && (cycle <= 9'd256);
      // cycle 256 wraps to 0 in 8 bits, so the subtraction still yields 255
      wr_addr   = cycle[7:0] - 8'd1;
      advance   = !out_valid || out_ready;
      line_done = (rd_state == R_STREAM) && out_valid && out_ready && (out_x == 8'd255);
      commit    = (wr_state == W_COMMIT);
      // A bank released by the reader on this same edge is already free for the commit.
      wr_free   = !full[wr_bank] || (line_done && (rd_bank == wr_bank));
      commit_ok = commit && wr_free;
      drop      = commit && !wr_free;
      rd_issue  = advance && !rd_cnt[8] && ((rd_state == R_STREAM) || full[rd_bank]);
   end

   always_comb begin
      wr_state_n = wr_state;
      case (wr_state)
         W_WAIT: begin
            if ((cycle == 9'd0) && (scanline <= 9'd239)) wr_state_n = W_CAPTURE;
         end
         W_CAPTURE: begin
            if (cycle == 9'd257)     wr_state_n = W_COMMIT;
            else if (cycle > 9'd257) wr_state_n = W_WAIT;  // timing jumped, abandon line
         end
         W_COMMIT: wr_state_n = W_WAIT;
         default:  wr_state_n = W_WAIT;
      endcase
   end

   always_comb begin
      rd_state_n = rd_state;
      case (rd_state)
         R_IDLE:   if (rd_issue)  rd_state_n = R_STREAM;
         R_STREAM: if (line_done) rd_state_n = R_IDLE;
         default:  rd_state_n = R_IDLE;
      endcase
   end

   // Release is applied first so a commit into the just-freed bank wins.
   always_comb begin
      full_n = full;
      if (line_done) full_n[rd_bank] = 1'b0;
      if (commit_ok) full_n[wr_bank] = 1'b1;
   end

`ifdef PPU_STREAM_PALETTE_EN
   function automatic logic [15:0] pk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      pk = ((16'(r) >> 3) << 11) | ((16'(g) >> 2) << 5) | (16'(b) >> 3);
   endfunction

   always_comb begin
      s1_pix = 16'h0000;
      case (s1_idx)
         6'h00: s1_pix = pk(8'd84,  8'd84,  8'd84);
         6'h01: s1_pix = pk(8'd0,   8'd30,  8'd116);
         6'h02: s1_pix = pk(8'd8,   8'd16,  8'd144);
         6'h03: s1_pix = pk(8'd48,  8'd0,   8'd136);
         6'h04: s1_pix = pk(8'd68,  8'd0,   8'd100);
         6'h05: s1_pix = pk(8'd92,  8'd0,   8'd48);
         6'h06: s1_pix = pk(8'd84,  8'd4,   8'd0);
         6'h07: s1_pix = pk(8'd60,  8'd24,  8'd0);
         6'h08: s1_pix = pk(8'd32,  8'd42,  8'd0);
         6'h09: s1_pix = pk(8'd8,   8'd58,  8'd0);
         6'h0A: s1_pix = pk(8'd0,   8'd64,  8'd0);
         6'h0B: s1_pix = pk(8'd0,   8'd60,  8'd0);
         6'h0C: s1_pix = pk(8'd0,   8'd50,  8'd60);
         6'h10: s1_pix = pk(8'd152, 8'd150, 8'd152);
         6'h11: s1_pix = pk(8'd8,   8'd76,  8'd196);
         6'h12: s1_pix = pk(8'd48,  8'd50,  8'd236);
         6'h13: s1_pix = pk(8'd92,  8'd30,  8'd228);
         6'h14: s1_pix = pk(8'd136, 8'd20,  8'd176);
         6'h15: s1_pix = pk(8'd160, 8'd20,  8'd100);
         6'h16: s1_pix = pk(8'd152, 8'd34,  8'd32);
         6'h17: s1_pix = pk(8'd120, 8'd60,  8'd0);
         6'h18: s1_pix = pk(8'd84,  8'd90,  8'd0);
         6'h19: s1_pix = pk(8'd40,  8'd114, 8'd0);
         6'h1A: s1_pix = pk(8'd8,   8'd124, 8'd0);
         6'h1B: s1_pix = pk(8'd0,   8'd118, 8'd40);
         6'h1C: s1_pix = pk(8'd0,   8'd102, 8'd120);
         6'h20: s1_pix = pk(8'd236, 8'd238, 8'd236);
         6'h21: s1_pix = pk(8'd76,  8'd154, 8'd236);
         6'h22: s1_pix = pk(8'd120, 8'd124, 8'd236);
         6'h23: s1_pix = pk(8'd176, 8'd98,  8'd236);
         6'h24: s1_pix = pk(8'd228, 8'd84,  8'd236);
         6'h25: s1_pix = pk(8'd236, 8'd88,  8'd180);
         6'h26: s1_pix = pk(8'd236, 8'd106, 8'd100);
         6'h27: s1_pix = pk(8'd212, 8'd136, 8'd32);
         6'h28: s1_pix = pk(8'd160, 8'd170, 8'd0);
         6'h29: s1_pix = pk(8'd116, 8'd196, 8'd0);
         6'h2A: s1_pix = pk(8'd76,  8'd208, 8'd32);
         6'h2B: s1_pix = pk(8'd56,  8'd204, 8'd108);
         6'h2C: s1_pix = pk(8'd56,  8'd180, 8'd204);
         6'h2D: s1_pix = pk(8'd60,  8'd60,  8'd60);
         6'h30: s1_pix = pk(8'd236, 8'd238, 8'd236);
         6'h31: s1_pix = pk(8'd168, 8'd204, 8'd236);
         6'h32: s1_pix = pk(8'd188, 8'd188, 8'd236);
         6'h33: s1_pix = pk(8'd212, 8'd178, 8'd236);
         6'h34: s1_pix = pk(8'd236, 8'd174, 8'd236);
         6'h35: s1_pix = pk(8'd236, 8'd174, 8'd212);
         6'h36: s1_pix = pk(8'd236, 8'd180, 8'd176);
         6'h37: s1_pix = pk(8'd228, 8'd196, 8'd144);
         6'h38: s1_pix = pk(8'd204, 8'd210, 8'd120);
         6'h39: s1_pix = pk(8'd180, 8'd222, 8'd120);
         6'h3A: s1_pix = pk(8'd168, 8'd226, 8'd144);
         6'h3B: s1_pix = pk(8'd152, 8'd226, 8'd180);
         6'h3C: s1_pix = pk(8'd160, 8'd214, 8'd228);
         6'h3D: s1_pix = pk(8'd160, 8'd162, 8'd160);
         default: s1_pix = 16'h0000;   // the black entries
      endcase
   end
`else
   always_comb begin
      s1_pix = {10'b0, s1_idx};
   end
`endif

   always_ff @(posedge clk_ppu) begin
      if (ram_we)   line_ram[{wr_bank, wr_addr}] <= video;
      if (rd_issue) s1_idx <= line_ram[{rd_bank, rd_cnt[7:0]}];
   end

   always_ff @(posedge clk_ppu) begin
      if (!resetn) begin
         wr_state      <= W_WAIT;
         rd_state      <= R_IDLE;
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         full          <= 2'b00;
         row_tag[0]    <= 8'd0;
         row_tag[1]    <= 8'd0;
         rd_cnt        <= 9'd0;
         s1_valid      <= 1'b0;
         s1_x          <= 8'd0;
         s1_y          <= 8'd0;
         out_valid     <= 1'b0;
         out_data      <= 16'h0000;
         out_x         <= 8'd0;
         out_y         <= 8'd0;
         out_sol       <= 1'b0;
         out_sof       <= 1'b0;
         overflow      <= 1'b0;
         lines_dropped <= 8'd0;
      end else begin
         wr_state <= wr_state_n;
         rd_state <= rd_state_n;
         full     <= full_n;

         if (commit_ok) begin
            row_tag[wr_bank] <= scanline[7:0];
            wr_bank          <= !wr_bank;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (lines_dropped != 8'hFF) lines_dropped <= lines_dropped + 8'd1;
         end

         if (line_done) begin
            rd_bank <= !rd_bank;
            rd_cnt  <= 9'd0;
         end else if (rd_issue) begin
            rd_cnt  <= rd_cnt + 9'd1;
         end

         // Both stages move together so a stalled output freezes the whole pipe.
         if (advance) begin
            out_valid <= s1_valid;
            out_data  <= s1_pix;
            out_x     <= s1_x;
            out_y     <= s1_y;
            out_sol   <= (s1_x == 8'd0);
            out_sof   <= (s1_x == 8'd0) && (s1_y == 8'd0);
            s1_valid  <= rd_issue;
            if (rd_issue) begin
               s1_x <= rd_cnt[7:0];
               s1_y <= row_tag[rd_bank];
            end
         end
      end
   end

endmodule

// File: tb/tb_ppu_line_streamer.sv
// tb/tb_ppu_line_streamer.sv - directed self-checking bench for ppu_line_streamer

module tb_ppu_line_streamer;

   logic        clk_ppu;
   logic        resetn;
   logic [5:0]  video;
   logic [8:0]  scanline;
   logic [8:0]  cycle;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [7:0]  out_x;
   logic [7:0]  out_y;
   logic        out_sol;
   logic        out_sof;
   logic        overflow;
   logic [7:0]  lines_dropped;

   ppu_line_streamer dut (
      .clk_ppu       (clk_ppu),
      .resetn        (resetn),
      .video         (video),
      .scanline      (scanline),
      .cycle         (cycle),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_x         (out_x),
      .out_y         (out_y),
      .out_sol       (out_sol),
      .out_sof       (out_sof),
      .overflow      (overflow),
      .lines_dropped (lines_dropped)
   );

   initial clk_ppu = 1'b0;
   always #5 clk_ppu = ~clk_ppu;

   typedef struct packed {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [15:0] d;
      logic        sol;
      logic        sof;
   } pix_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   pix_t q[$];
   pix_t cur;
   pix_t held;
   logic stall_prev = 1'b0;
   int   fv;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transfer monitor and stall-stability checker.
   always @(negedge clk_ppu) begin
      cur = '{x: out_x, y: out_y, d: out_data, sol: out_sol, sof: out_sof};
      if (!resetn) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'(cur), 64'(held));
         end
         if (out_valid && out_ready) q.push_back(cur);
         stall_prev = out_valid && !out_ready;
         held       = cur;
      end
   end

   // rmode: 0 ready high, 1 ready low, 2 ready toggling. resetn is low for cycles [rst_from, rst_to).
   task automatic drive_line(input int sl, input int rmode, input int spr_x,
                             input int rst_from, input int rst_to, output int first_v);
      first_v = -1;
      for (int c = 0; c < 341; c++) begin
         @(posedge clk_ppu); #1;
         if (first_v < 0 && out_valid) first_v = c;
         if (rst_to > rst_from && c == rst_from + 1)
            chk("reset_outputs", 64'({out_valid, out_data, out_x, out_y, out_sol, out_sof,
                                      overflow, lines_dropped}), 64'd0);
         scanline  = 9'(sl);
         cycle     = 9'(c);
         video     = (c - 1 == spr_x) ? 6'h20 : 6'(sl);
         out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'b0 : 1'(c % 2);
         resetn    = !(c >= rst_from && c < rst_to);
      end
   endtask

   task automatic check_row(input int y, input bit chk_data, input int spr_x);
      int bx, by, bs, bf, bd;
      pix_t p;
      logic [5:0] idx;
      bx = 0; by = 0; bs = 0; bf = 0; bd = 0;
      chk($sformatf("row%0d_count", y), 64'(q.size() >= 256), 64'd1);
      if (q.size() < 256) return;
      for (int i = 0; i < 256; i++) begin
         p = q.pop_front();
         if (p.x != 8'(i)) bx++;
         if (p.y != 8'(y)) by++;
         if (p.sol != (i == 0)) bs++;
         if (p.sof != (i == 0 && y == 0)) bf++;
         idx = (i == spr_x) ? 6'h20 : 6'(y);
`ifdef PPU_STREAM_PALETTE_EN
         if (chk_data && idx == 6'h20 && p.d != 16'hEF7D) bd++;
         if (chk_data && idx == 6'h0F && p.d != 16'h0000) bd++;
`else
         if (chk_data && p.d != {10'b0, idx}) bd++;
`endif
      end
      chk($sformatf("row%0d_x", y),    64'(bx), 64'd0);
      chk($sformatf("row%0d_y", y),    64'(by), 64'd0);
      chk($sformatf("row%0d_sol", y),  64'(bs), 64'd0);
      chk($sformatf("row%0d_sof", y),  64'(bf), 64'd0);
      chk($sformatf("row%0d_data", y), 64'(bd), 64'd0);
   endtask

   initial begin
      resetn    = 1'b0;
      video     = 6'd0;
      scanline  = 9'd0;
      cycle     = 9'd0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk_ppu);
      #1;
      chk("reset_values", 64'({out_valid, out_data, out_x, out_y, out_sol, out_sof,
                               overflow, lines_dropped}), 64'd0);

      // vblank line is never captured
      drive_line(245, 0, 999, 0, 0, fv);
      chk("vblank_no_output", 64'(q.size()), 64'd0);

      // free-running, ready high, sprite at (8,8), index 0x0F on row 15
      drive_line(0, 0, 999, 0, 0, fv);
      chk("first_valid_latency", 64'(fv), 64'd261);
      drive_line(1,   0, 999, 0, 0, fv);
      drive_line(8,   0, 8,   0, 0, fv);
      drive_line(15,  0, 999, 0, 0, fv);
      drive_line(239, 0, 999, 0, 0, fv);
      drive_line(240, 0, 999, 0, 0, fv);
      check_row(0,   1, 999);
      check_row(1,   1, 999);
      check_row(8,   1, 8);
      check_row(15,  1, 999);
      check_row(239, 1, 999);
      chk("free_run_no_extra", 64'(q.size()), 64'd0);
      chk("free_run_overflow", 64'(overflow), 64'd0);

      // consumer stalled from frame start
      drive_line(0, 1, 999, 0, 0, fv);
      drive_line(1, 1, 999, 0, 0, fv);
      chk("stall_no_drop_yet", 64'(overflow), 64'd0);
      drive_line(2, 1, 999, 0, 0, fv);
      chk("stall_overflow", 64'(overflow), 64'd1);
      chk("stall_dropped1", 64'(lines_dropped), 64'd1);
      drive_line(3, 1, 999, 0, 0, fv);
      chk("stall_dropped2", 64'(lines_dropped), 64'd2);
      chk("stall_no_transfer", 64'(q.size()), 64'd0);
      drive_line(245, 0, 999, 0, 0, fv);
      drive_line(246, 0, 999, 0, 0, fv);
      check_row(0, 0, 999);
      check_row(1, 1, 999);
      chk("stall_no_extra", 64'(q.size()), 64'd0);

      // ready toggling every cycle
      drive_line(10,  2, 999, 0, 0, fv);
      drive_line(11,  2, 999, 0, 0, fv);
      drive_line(12,  2, 999, 0, 0, fv);
      drive_line(245, 2, 999, 0, 0, fv);
      drive_line(246, 2, 999, 0, 0, fv);
      drive_line(247, 2, 999, 0, 0, fv);
      check_row(10, 1, 999);
      check_row(11, 1, 999);
      check_row(12, 1, 999);
      chk("toggle_no_extra", 64'(q.size()), 64'd0);
      chk("toggle_no_drop", 64'(lines_dropped), 64'd2);

      // reset pulse at cycle 100 of line 50
      drive_line(245, 0, 999, 0, 0, fv);
      drive_line(50,  0, 999, 100, 101, fv);
      chk("pulse_no_row50", 64'(q.size()), 64'd0);
      drive_line(51,  0, 999, 0, 0, fv);
      chk("pulse_row51_latency", 64'(fv), 64'd261);
      drive_line(245, 0, 999, 0, 0, fv);
      check_row(51, 1, 999);
      chk("pulse_no_extra", 64'(q.size()), 64'd0);

      // reset released mid-line at cycle 200
      drive_line(60,  0, 999, 0, 200, fv);
      drive_line(61,  0, 999, 0, 0, fv);
      drive_line(245, 0, 999, 0, 0, fv);
      chk("midline_first_row", 64'(q.size() > 0 ? q[0].y : 8'hFF), 64'd61);
      check_row(61, 1, 999);
      chk("midline_no_extra", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
